hamming_12_8_encoder_tx: RTL and testbench

- Transmit end of the Hamming(12,8) single-error-correcting link.
- Accepts 8-bit data bytes through a valid/ready handshake and computes 4 even-parity bits to form a 12-bit codeword.
- Buffers one codeword and shifts it out on a framed serial line.
- Its codeword layout matches the receiver's syndrome-to-data-bit mapping: syndromes 3, 5, 6, 7, 9, 10, 11, 12 select data bits 1 to 8.

---
 rtl/hamming_12_8_encoder_tx_if.sv | 24 ++
 rtl/hamming_12_8_encoder_tx.sv | 152 +++++++++++++++
 tb/tb_hamming_12_8_encoder_tx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hamming_12_8_encoder_tx_if.sv
// rtl/hamming_12_8_encoder_tx_if.sv - byte intake handshake for the Hamming(12,8) transmitter
interface hamming_12_8_encoder_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_in;
  logic       inj_en;
  logic [3:0] inj_pos;

  modport master (
    output in_valid,
    output data_in,
    output inj_en,
    output inj_pos,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  data_in,
    input  inj_en,
    input  inj_pos,
    output in_ready
  );
endinterface

// File: rtl/hamming_12_8_encoder_tx.sv
// rtl/hamming_12_8_encoder_tx.sv - Hamming(12,8) encoder with one-deep buffer and framed serial output
module hamming_12_8_encoder_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  hamming_12_8_encoder_tx_if.slave   bus,
  output logic [11:0]                cw_out,
  output logic                       cw_valid,
  output logic                       tx_line,
  output logic                       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] clk_cnt, clk_cnt_d;
  logic [3:0]    bit_cnt, bit_cnt_d;
  logic [11:0]   shreg, shreg_d;
  logic [11:0]   buf_q;
  logic          buf_full;
  logic          unload;
  logic          accept;
  logic          tick;
  logic [11:0]   inj_mask;
  logic [11:0]   enc_word;

  // Layout p1..p12 = P1 P2 D1 P4 D2 D3 D4 P8 D5 D6 D7 D8, so the receiver's
  // syndrome value directly names the flipped position.
  function automatic logic [11:0] encode(input logic [7:0] d);
    logic p1, p2, p4, p8;
    p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    p4 = d[1] ^ d[2] ^ d[3] ^ d[7];
    p8 = d[4] ^ d[5] ^ d[6] ^ d[7];
    return {d[7:4], p8, d[3:1], p4, d[0], p2, p1};
  endfunction

  always_comb begin
    inj_mask = '0;
    if (bus.inj_en && (bus.inj_pos >= 4'd1) && (bus.inj_pos <= 4'd12))
      inj_mask[bus.inj_pos - 4'd1] = 1'b1;
  end

  assign enc_word     = encode(bus.data_in) ^ inj_mask;
  assign bus.in_ready = ~buf_full;
  assign accept       = bus.in_valid & ~buf_full;
  assign tick         = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign busy         = buf_full | (state != IDLE);

  always_comb begin
    state_d   = state;
    clk_cnt_d = clk_cnt;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    unload    = 1'b0;
    case (state)
      IDLE: begin
        if (buf_full) begin
          state_d   = START;
          unload    = 1'b1;
          clk_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          clk_cnt_d = '0;
          bit_cnt_d = 4'd0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt + CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          clk_cnt_d = '0;
          shreg_d   = {1'b0, shreg[11:1]};
          if (bit_cnt == 4'd11) begin
            bit_cnt_d = 4'd0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt + 4'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt + CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          clk_cnt_d = '0;
          // A waiting codeword goes straight into the next start bit, no idle gap.
          if (buf_full) begin
            state_d = START;
            unload  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (unload)
      shreg_d = buf_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_d;
      clk_cnt <= clk_cnt_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
    end
  end

  // Load and unload cannot coincide: accept needs an empty buffer, unload a full one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q    <= '0;
      buf_full <= 1'b0;
      cw_out   <= '0;
      cw_valid <= 1'b0;
    end else begin
      cw_valid <= accept;
      if (accept) begin
        buf_q    <= enc_word;
        buf_full <= 1'b1;
        cw_out   <= enc_word;
      end else if (unload) begin
        buf_full <= 1'b0;
      end
    end
  end

  always_comb begin
    tx_line = 1'b1;
    case (state)
      START:   tx_line = 1'b0;
      DATA:    tx_line = shreg[0];
      default: tx_line = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_hamming_12_8_encoder_tx.sv
// tb/tb_hamming_12_8_encoder_tx.sv - directed self-checking bench for hamming_12_8_encoder_tx
module tb_hamming_12_8_encoder_tx;
  localparam int CPB = 4;

  logic        clk;
  logic        rst_n;
  logic [11:0] cw_out;
  logic        cw_valid;
  logic        tx_line;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  hamming_12_8_encoder_tx_if bus ();

  hamming_12_8_encoder_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cw_out   (cw_out),
    .cw_valid (cw_valid),
    .tx_line  (tx_line),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Offer a byte, wait (bounded) for acceptance, then check the codeword update.
  task automatic send(input logic [7:0] d, input logic ie, input logic [3:0] ip, input logic [11:0] expcw);
    int n;
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    bus.inj_en   = ie;
    bus.inj_pos  = ip;
    n = 0;
    while (!bus.in_ready && n < 500) begin
      step();
      n++;
    end
    chk("accept_timeout", (n < 500) ? 32'd1 : 32'd0, 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.inj_en   = 1'b0;
    chk("cw_valid_pulse", {31'd0, cw_valid}, 32'd1);
    chk("cw_out", {20'd0, cw_out}, {20'd0, expcw});
  endtask

  // Called in the first START cycle; walks the whole frame then checks busy.
  task automatic frame_check(input logic [11:0] cw);
    int errs;
    logic expbit;
    errs = 0;
    for (int i = 0; i < 14 * CPB; i++) begin
      if (i < CPB) expbit = 1'b0;
      else if (i >= 13 * CPB) expbit = 1'b1;
      else expbit = cw[(i / CPB) - 1];
      if (tx_line !== expbit) errs++;
      step();
    end
    chk("frame_bits", errs, 0);
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
  endtask

  task automatic start_and_frame(input logic [11:0] cw);
    step();
    chk("cw_valid_drop", {31'd0, cw_valid}, 32'd0);
    chk("start_bit", {31'd0, tx_line}, 32'd0);
    frame_check(cw);
  endtask

  initial begin
    int pulses;
    int stall_errs;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.data_in  = 8'h00;
    bus.inj_en   = 1'b0;
    bus.inj_pos  = 4'd0;
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_tx_line", {31'd0, tx_line}, 32'd1);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cw_out", {20'd0, cw_out}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      if (cw_valid !== 1'b0) pulses++;
      step();
    end
    chk("idle_no_pulse", pulses, 0);

    send(8'h00, 1'b0, 4'd0, 12'h000);
    start_and_frame(12'h000);
    send(8'h01, 1'b0, 4'd0, 12'h007);
    start_and_frame(12'h007);
    send(8'h80, 1'b0, 4'd0, 12'h888);
    start_and_frame(12'h888);
    send(8'hFF, 1'b0, 4'd0, 12'hF77);
    start_and_frame(12'hF77);

    // Back-to-back traffic; frame 1 starts at edge E1, second byte taken at E1+1.
    bus.in_valid = 1'b1;
    bus.data_in  = 8'h01;
    chk("b2b_ready0", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("b2b_cw1", {20'd0, cw_out}, 32'h007);
    bus.data_in = 8'h80;
    chk("b2b_full", {31'd0, bus.in_ready}, 32'd0);
    step();
    chk("b2b_start1", {31'd0, tx_line}, 32'd0);
    chk("b2b_ready_at_start", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("b2b_cw2_valid", {31'd0, cw_valid}, 32'd1);
    chk("b2b_cw2", {20'd0, cw_out}, 32'h888);
    bus.data_in = 8'hFF;
    stall_errs = 0;
    for (int i = 0; i < 54; i++) begin
      if (bus.in_ready !== 1'b0) stall_errs++;
      step();
    end
    chk("b2b_third_stalled", stall_errs, 0);
    chk("b2b_stop_high", {31'd0, tx_line}, 32'd1);
    step();
    chk("b2b_contiguous_start", {31'd0, tx_line}, 32'd0);
    chk("b2b_ready_frame2", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("b2b_cw3", {20'd0, cw_out}, 32'hF77);
    repeat (55) step();
    frame_check(12'hF77);

    send(8'h00, 1'b1, 4'd5, 12'h010);
    start_and_frame(12'h010);
    send(8'h00, 1'b1, 4'd0, 12'h000);
    start_and_frame(12'h000);
    send(8'h00, 1'b1, 4'd14, 12'h000);
    start_and_frame(12'h000);

    // Reset in the middle of the data bits, with a byte offered on the same edge.
    send(8'hFF, 1'b0, 4'd0, 12'hF77);
    repeat (26) step();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.data_in  = 8'h00;
    step();
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    chk("mid_rst_tx", {31'd0, tx_line}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_cw_out", {20'd0, cw_out}, 32'd0);
    step();
    chk("mid_rst_dropped", {31'd0, busy}, 32'd0);
    chk("mid_rst_no_pulse", {31'd0, cw_valid}, 32'd0);
    send(8'h80, 1'b0, 4'd0, 12'h888);
    start_and_frame(12'h888);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
